multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle RV32I main control state machine; drives the datapath's enables and muxes and issues the 2-bit `ALUOp` class consumed by the ALU control decoder (00 = add, 01 = branch compare, 10 = funct-decoded R/I). One instruction is sequenced through IF/ID/EX/MEM/WB-style states. Control outputs are a Moore decode of the current state, except the branch PC write, which is qualified by `bcond`.

## Interface
- No parameters; all encodings are fixed.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: `IR[6:0]`, valid from ID onward.
- `bcond` in 1: ALU branch-compare result, valid in EX_BR.
- `halt_cond` in 1: datapath flag, x17 == 10, sampled in ID.
- `pc_write`, `mem_read`, `mem_write`, `ir_write`, `reg_write` out 1 each.
  - `ir_write` also latches `old_pc` = PC in the datapath.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `pc_source` out 1: PC input select; 0 = ALU result, 1 = ALUOut.
- `alu_src_a` out 2: 00 = PC, 01 = rs1, 10 = `old_pc`.
- `alu_src_b` out 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` out 2: ALU class, encoded as in the summary.
- `wb_sel` out 2: register write-back select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `is_ecall` out 1: high in ID when opcode = 1110011.
- `halted` out 1: sticky halt flag.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `state` out 4: current state, for verification.

## Operation
- States and encodings:
  - IF=0, ID=1, EX_ALU=2, EX_ADDR=3, EX_BR=4, BR_TGT=5.
  - EX_JAL=6, EX_JALR=7, MEM_LD=8, MEM_ST=9, WB_LD=10, WB_ALU=11, HALT=12.
  - Codes 13–15 are illegal and return to IF.
- Any output not listed for a state is 0.
- IF:
  - Asserts `mem_read`, `ir_write`, `pc_write`; `alu_src_a`=00, `alu_src_b`=01, `ALUOp`=00, `pc_source`=0, so PC ← PC+4.
  - Next state: ID.
- ID: dispatch on `opcode`.
  - 0110011 / 0010011 → EX_ALU.
  - 0000011 / 0100011 → EX_ADDR.
  - 1100011 → EX_BR.
  - 1101111 → EX_JAL.
  - 1100111 → EX_JALR.
  - 1110011 → HALT if `halt_cond`=1, else IF with `instr_done`.
  - Any other opcode is a NOP: → IF with `instr_done`.
- EX_ALU:
  - `alu_src_a`=01; `alu_src_b` = 00 for R-type, 10 for I-type; `ALUOp`=10.
  - Next state: WB_ALU.
- WB_ALU: `reg_write`, `wb_sel`=00, `instr_done`; → IF.
- EX_ADDR:
  - `alu_src_a`=01, `alu_src_b`=10, `ALUOp`=00.
  - Next state: MEM_LD for loads, MEM_ST for stores.
- MEM_LD: `mem_read`, `i_or_d`=1; → WB_LD.
- WB_LD: `reg_write`, `wb_sel`=01, `instr_done`; → IF.
- MEM_ST: `mem_write`, `i_or_d`=1, `instr_done`; → IF.
- EX_BR:
  - `alu_src_a`=01, `alu_src_b`=00, `ALUOp`=01.
  - `bcond`=0: → IF with `instr_done`.
  - `bcond`=1: → BR_TGT.
- BR_TGT:
  - `alu_src_a`=10, `alu_src_b`=10, `ALUOp`=00, `pc_write`, `pc_source`=0, `instr_done`.
  - Next state: IF.
- EX_JAL / EX_JALR:
  - `alu_src_a` = 10 for JAL, 01 for JALR; `alu_src_b`=10, `ALUOp`=00.
  - `pc_write`, `pc_source`=0, `reg_write`, `wb_sel`=10, `instr_done`.
  - The register file captures the pre-update PC, i.e. `old_pc`+4. The datapath clears the JALR target LSB.
  - Next state: IF.
- HALT: absorbing state; all enables 0, `halted`=1. Only `reset` exits.

## Timing
- Reset:
  - While `reset`=1, every output is forced to 0 and `state` loads IF on the clock edge.
  - The first IF cycle is the first cycle with `reset`=0.
  - Reset asserted in any state, including HALT, aborts the instruction; no enable is asserted in that cycle.
- Cycles per instruction:

  | Instruction | Cycles |
  |---|---|
  | R/I-type | 4 |
  | Load | 5 |
  | Store | 4 |
  | Branch not taken | 3 |
  | Branch taken | 4 |
  | JAL / JALR | 3 |
  | ECALL / NOP | 2 |

- `instr_done` is exactly one cycle per retired instruction. It is never asserted in HALT.
- `pc_write` asserts at most once per instruction beyond IF.
- `halted` rises in the cycle after ID of a halting ECALL.

## Configuration
- `BRANCH_TARGET_PRECOMPUTE_EN`:
  - Defined:
    - ID computes `old_pc`+imm into ALUOut (`alu_src_a`=10, `alu_src_b`=10, `ALUOp`=00).
    - In EX_BR, `pc_write` = `bcond` with `pc_source`=1, and the next state is always IF.
    - BR_TGT is unreachable; a taken branch takes 3 cycles.
  - Undefined: behaviour as specified above, with ID's ALU controls all 0.

## Test plan
- Reset released, opcode 0110011 → `state` sequence 0,1,2,11,0:
  - `ALUOp`=10 in EX_ALU.
  - `reg_write`=1 and `instr_done`=1 in WB_ALU only.
- Load (0000011) → `state` sequence 0,1,3,8,10, `instr_done` on cycle 5. Store (0100011) → `state` sequence 0,1,3,9, with `mem_write`=1 only in MEM_ST.
- Branch with `bcond`=0 → 3 cycles, no `pc_write` after IF. With `bcond`=1 → BR_TGT asserting `pc_write`, 4 cycles; 3 cycles with `BRANCH_TARGET_PRECOMPUTE_EN` defined.
- JAL → EX_JAL asserts `pc_write`, `reg_write`, `wb_sel`=10, `alu_src_a`=10 together; next state IF.
- ECALL with `halt_cond`=1 → `halted`=1 from the next cycle, all enables held 0 for 20+ cycles. `reset` pulse → IF with `halted`=0.
- Opcode 1111111 → 2-cycle NOP. `reset` asserted in MEM_LD → `mem_read`=0 in that cycle, `state`=0 next.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I main controller (master) and its datapath (slave).
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       pc_write;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       i_or_d;
  logic       pc_source;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ALUOp;
  logic [1:0] wb_sel;
  logic       is_ecall;
  logic       halted;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, bcond, halt_cond,
    output pc_write, mem_read, mem_write, ir_write, reg_write, i_or_d, pc_source,
           alu_src_a, alu_src_b, ALUOp, wb_sel, is_ecall, halted, instr_done, state
  );

  modport slave (
    output opcode, bcond, halt_cond,
    input  pc_write, mem_read, mem_write, ir_write, reg_write, i_or_d, pc_source,
           alu_src_a, alu_src_b, ALUOp, wb_sel, is_ecall, halted, instr_done, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM. Optional build macro BRANCH_TARGET_PRECOMPUTE_EN
// computes the branch target in ID so a taken branch retires from EX_BR.
//
// state   | meaning
// IF      | fetch, IR <- mem[PC], PC <- PC+4
// ID      | decode / dispatch on opcode
// EX_ALU  | R/I-type execute
// EX_ADDR | load/store address
// EX_BR   | branch compare
// BR_TGT  | taken branch, PC <- old_pc+imm
// EX_JAL  | JAL jump + link
// EX_JALR | JALR jump + link
// MEM_LD  | load memory read
// MEM_ST  | store memory write
// WB_LD   | load write-back
// WB_ALU  | ALU write-back
// HALT    | absorbing halt
module multicycle_control_fsm (
  input  logic clk,
  input  logic reset,
  multicycle_control_fsm_if.master ctrl
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_ALU  = 4'd2,
    S_EX_ADDR = 4'd3,
    S_EX_BR   = 4'd4,
    S_BR_TGT  = 4'd5,
    S_EX_JAL  = 4'd6,
    S_EX_JALR = 4'd7,
    S_MEM_LD  = 4'd8,
    S_MEM_ST  = 4'd9,
    S_WB_LD   = 4'd10,
    S_WB_ALU  = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  state_t state_q;
  logic   id_retires;

  // ECALL without halt and unknown opcodes finish in ID
  always_comb begin
    id_retires = 1'b0;
    case (ctrl.opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: id_retires = 1'b0;
      OP_SYSTEM: id_retires = ~ctrl.halt_cond;
      default:   id_retires = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          case (ctrl.opcode)
            OP_R, OP_I:         state_q <= S_EX_ALU;
            OP_LOAD, OP_STORE:  state_q <= S_EX_ADDR;
            OP_BRANCH:          state_q <= S_EX_BR;
            OP_JAL:             state_q <= S_EX_JAL;
            OP_JALR:            state_q <= S_EX_JALR;
            OP_SYSTEM:          state_q <= ctrl.halt_cond ? S_HALT : S_IF;
            default:            state_q <= S_IF;
          endcase
        end
        S_EX_ALU:  state_q <= S_WB_ALU;
        S_EX_ADDR: state_q <= (ctrl.opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
        S_MEM_LD:  state_q <= S_WB_LD;
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
        S_EX_BR:   state_q <= S_IF;
`else
        S_EX_BR:   state_q <= ctrl.bcond ? S_BR_TGT : S_IF;
`endif
        S_HALT:    state_q <= S_HALT;
        default:   state_q <= S_IF;
      endcase
    end
  end

  // Moore decode of state; reset masks every output in the same cycle
  always_comb begin
    ctrl.pc_write   = 1'b0;
    ctrl.mem_read   = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.i_or_d     = 1'b0;
    ctrl.pc_source  = 1'b0;
    ctrl.alu_src_a  = 2'b00;
    ctrl.alu_src_b  = 2'b00;
    ctrl.ALUOp      = 2'b00;
    ctrl.wb_sel     = 2'b00;
    ctrl.is_ecall   = 1'b0;
    ctrl.halted     = 1'b0;
    ctrl.instr_done = 1'b0;
    ctrl.state      = 4'd0;
    if (!reset) begin
      ctrl.state = state_q;
      case (state_q)
        S_IF: begin
          ctrl.mem_read  = 1'b1;
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_b = 2'b01;
        end
        S_ID: begin
          ctrl.is_ecall   = (ctrl.opcode == OP_SYSTEM);
          ctrl.instr_done = id_retires;
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
          ctrl.alu_src_a  = 2'b10;
          ctrl.alu_src_b  = 2'b10;
`endif
        end
        S_EX_ALU: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = (ctrl.opcode == OP_R) ? 2'b00 : 2'b10;
          ctrl.ALUOp     = 2'b10;
        end
        S_WB_ALU: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_EX_ADDR: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = 2'b10;
        end
        S_MEM_LD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_WB_LD: begin
          ctrl.reg_write  = 1'b1;
          ctrl.wb_sel     = 2'b01;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_ST: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_EX_BR: begin
          ctrl.alu_src_a  = 2'b01;
          ctrl.ALUOp      = 2'b01;
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
          ctrl.pc_write   = ctrl.bcond;
          ctrl.pc_source  = 1'b1;
          ctrl.instr_done = 1'b1;
`else
          ctrl.instr_done = ~ctrl.bcond;
`endif
        end
        S_BR_TGT: begin
          ctrl.alu_src_a  = 2'b10;
          ctrl.alu_src_b  = 2'b10;
          ctrl.pc_write   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_EX_JAL, S_EX_JALR: begin
          ctrl.alu_src_a  = (state_q == S_EX_JAL) ? 2'b10 : 2'b01;
          ctrl.alu_src_b  = 2'b10;
          ctrl.pc_write   = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.wb_sel     = 2'b10;
          ctrl.instr_done = 1'b1;
        end
        S_HALT: ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: vector table, corner sequences, random instruction stream.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if io ();
  multicycle_control_fsm dut (.clk(clk), .reset(reset), .ctrl(io));

  typedef struct packed {
    logic       pc_write, mem_read, mem_write, ir_write, reg_write, i_or_d, pc_source;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic       is_ecall, halted, instr_done;
  } outs_t;

  typedef struct {
    logic [6:0]  op;
    logic        bc;
    int          cycles;
    logic [31:0] seq;
    int          pcw, rw, mr, mw;
  } vec_t;

  typedef struct { int cycles, pcw, rw, mr, mw; } exp_t;

  int n_pass = 0;
  int n_total = 0;

  int          r_cycles, r_pcw, r_rw, r_mr, r_mw;
  logic [31:0] r_seq;
  logic        r_halted;
  outs_t       out_at [16];

  function automatic outs_t sample_outs();
    outs_t o;
    o.pc_write = io.pc_write;   o.mem_read = io.mem_read;   o.mem_write = io.mem_write;
    o.ir_write = io.ir_write;   o.reg_write = io.reg_write; o.i_or_d = io.i_or_d;
    o.pc_source = io.pc_source; o.alu_src_a = io.alu_src_a; o.alu_src_b = io.alu_src_b;
    o.alu_op = io.ALUOp;        o.wb_sel = io.wb_sel;       o.is_ecall = io.is_ecall;
    o.halted = io.halted;       o.instr_done = io.instr_done;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-instruction cost derived from the instruction class, independent of any state walk
  function automatic exp_t model(input logic [6:0] op, input logic bc);
    exp_t e;
    e = '{2, 0, 0, 1, 0};
    if (op == OP_R || op == OP_I)        e = '{4, 0, 1, 1, 0};
    else if (op == OP_LOAD)              e = '{5, 0, 1, 2, 0};
    else if (op == OP_STORE)             e = '{4, 0, 0, 1, 1};
    else if (op == OP_JAL || op == OP_JALR) e = '{3, 1, 1, 1, 0};
    else if (op == OP_BRANCH) begin
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
      e = '{3, bc ? 1 : 0, 0, 1, 0};
`else
      e = bc ? '{4, 1, 0, 1, 0} : '{3, 0, 0, 1, 0};
`endif
    end
    return e;
  endfunction

  // Starts in an IF cycle; returns at the next IF cycle, or inside HALT
  task automatic run_instr(input logic [6:0] op, input logic bc, input logic hc);
    logic done;
    outs_t o;
    r_cycles = 0; r_pcw = 0; r_rw = 0; r_mr = 0; r_mw = 0; r_seq = '0; r_halted = 1'b0;
    io.opcode = op; io.bcond = bc; io.halt_cond = hc;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (io.state == 4'd12) begin
        r_halted = 1'b1;
        break;
      end
      o = sample_outs();
      r_cycles++;
      r_seq = (r_seq << 4) | 32'(io.state);
      out_at[io.state] = o;
      if (io.state != 4'd0 && o.pc_write) r_pcw++;
      if (o.reg_write) r_rw++;
      if (o.mem_read)  r_mr++;
      if (o.mem_write) r_mw++;
      done = o.instr_done;
      @(posedge clk); #1;
      if (done) break;
    end
  endtask

  vec_t vecs [11];
  logic [6:0] pool [9];
  outs_t halt_only;

  initial begin
    vecs[0]  = '{OP_R,      1'b0, 4, 32'h0012B, 0, 1, 1, 0};
    vecs[1]  = '{OP_I,      1'b1, 4, 32'h0012B, 0, 1, 1, 0};
    vecs[2]  = '{OP_LOAD,   1'b0, 5, 32'h0138A, 0, 1, 2, 0};
    vecs[3]  = '{OP_STORE,  1'b1, 4, 32'h00139, 0, 0, 1, 1};
    vecs[4]  = '{OP_BRANCH, 1'b0, 3, 32'h00014, 0, 0, 1, 0};
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
    vecs[5]  = '{OP_BRANCH, 1'b1, 3, 32'h00014, 1, 0, 1, 0};
`else
    vecs[5]  = '{OP_BRANCH, 1'b1, 4, 32'h00145, 1, 0, 1, 0};
`endif
    vecs[6]  = '{OP_JAL,    1'b0, 3, 32'h00016, 1, 1, 1, 0};
    vecs[7]  = '{OP_JALR,   1'b1, 3, 32'h00017, 1, 1, 1, 0};
    vecs[8]  = '{OP_SYSTEM, 1'b0, 2, 32'h00001, 0, 0, 1, 0};
    vecs[9]  = '{7'b1111111, 1'b1, 2, 32'h00001, 0, 0, 1, 0};
    vecs[10] = '{7'b0000000, 1'b0, 2, 32'h00001, 0, 0, 1, 0};
    pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, 7'b0001111};

    reset = 1'b1;
    io.opcode = OP_LOAD; io.bcond = 1'b1; io.halt_cond = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(sample_outs()), 32'd0);
    chk("reset_state", 32'(io.state), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].bc, 1'b0);
      chk($sformatf("v%0d_cycles", i), r_cycles, vecs[i].cycles);
      chk($sformatf("v%0d_seq", i), r_seq, vecs[i].seq);
      chk($sformatf("v%0d_pcw", i), r_pcw, vecs[i].pcw);
      chk($sformatf("v%0d_rw", i), r_rw, vecs[i].rw);
      chk($sformatf("v%0d_mr", i), r_mr, vecs[i].mr);
      chk($sformatf("v%0d_mw", i), r_mw, vecs[i].mw);
    end

    run_instr(OP_R, 1'b0, 1'b0);
    chk("if_enables", {out_at[0].pc_write, out_at[0].mem_read, out_at[0].ir_write, out_at[0].instr_done}, 4'b1110);
    chk("if_alu", {out_at[0].alu_src_a, out_at[0].alu_src_b, out_at[0].alu_op, out_at[0].pc_source}, 7'b0001000);
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
    chk("id_alu", {out_at[1].alu_src_a, out_at[1].alu_src_b, out_at[1].alu_op}, 6'b101000);
`else
    chk("id_alu", {out_at[1].alu_src_a, out_at[1].alu_src_b, out_at[1].alu_op}, 6'b000000);
`endif
    chk("exalu_r", {out_at[2].alu_src_a, out_at[2].alu_src_b, out_at[2].alu_op}, 6'b010010);
    chk("wbalu", {out_at[11].reg_write, out_at[11].wb_sel, out_at[11].instr_done}, 4'b1001);
    run_instr(OP_I, 1'b0, 1'b0);
    chk("exalu_i", {out_at[2].alu_src_a, out_at[2].alu_src_b, out_at[2].alu_op}, 6'b011010);
    run_instr(OP_LOAD, 1'b0, 1'b0);
    chk("exaddr", {out_at[3].alu_src_a, out_at[3].alu_src_b, out_at[3].alu_op}, 6'b011000);
    chk("memld", {out_at[8].mem_read, out_at[8].i_or_d, out_at[8].instr_done}, 3'b110);
    chk("wbld", {out_at[10].reg_write, out_at[10].wb_sel, out_at[10].instr_done}, 4'b1011);
    run_instr(OP_STORE, 1'b0, 1'b0);
    chk("memst", {out_at[9].mem_write, out_at[9].i_or_d, out_at[9].instr_done, out_at[9].mem_read}, 4'b1110);
    run_instr(OP_JAL, 1'b0, 1'b0);
    chk("jal", {out_at[6].pc_write, out_at[6].reg_write, out_at[6].wb_sel, out_at[6].alu_src_a,
                out_at[6].alu_src_b, out_at[6].pc_source, out_at[6].instr_done}, 11'b11_10_10_10_0_1);
    chk("jal_next", 32'(io.state), 32'd0);
    run_instr(OP_JALR, 1'b0, 1'b0);
    chk("jalr_src_a", 32'(out_at[7].alu_src_a), 32'd1);
    run_instr(OP_BRANCH, 1'b1, 1'b0);
    chk("exbr_alu", {out_at[4].alu_src_a, out_at[4].alu_src_b, out_at[4].alu_op}, 6'b010001);
`ifdef BRANCH_TARGET_PRECOMPUTE_EN
    chk("exbr_taken", {out_at[4].pc_write, out_at[4].pc_source, out_at[4].instr_done}, 3'b111);
`else
    chk("brtgt", {out_at[5].pc_write, out_at[5].pc_source, out_at[5].alu_src_a, out_at[5].alu_src_b,
                  out_at[5].instr_done}, 7'b1_0_10_10_1);
`endif

    run_instr(OP_SYSTEM, 1'b0, 1'b1);
    chk("ecall_cycles", r_cycles, 2);
    chk("ecall_flag", {out_at[1].is_ecall, out_at[1].instr_done, out_at[1].halted}, 3'b100);
    chk("halt_reached", 32'(r_halted), 32'd1);
    halt_only = '0;
    halt_only.halted = 1'b1;
    io.opcode = OP_R; io.halt_cond = 1'b0;
    for (int k = 0; k < 22; k++) begin
      chk("halt_hold", {28'(sample_outs()), io.state}, {28'(halt_only), 4'd12});
      @(posedge clk); #2;
    end
    reset = 1'b1;
    #1;
    chk("halt_reset_outs", {28'(sample_outs()), io.state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("after_reset", {io.state, io.halted, io.ir_write}, 6'b000001);

    io.opcode = OP_LOAD;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (io.state == 4'd8) break;
      @(posedge clk);
    end
    chk("reach_memld", 32'(io.state), 32'd8);
    reset = 1'b1;
    #1;
    chk("memld_reset", {io.mem_read, 28'(sample_outs())}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("memld_reset_next", {io.state, io.mem_read}, 5'b00001);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic bc, hc;
      exp_t e;
      int idx;
      idx = $urandom_range(0, 9);
      op = (idx == 9) ? 7'($urandom) : pool[idx];
      bc = 1'($urandom_range(0, 1));
      hc = (op == OP_SYSTEM) ? 1'b0 : 1'($urandom_range(0, 1));
      e = model(op, bc);
      run_instr(op, bc, hc);
      chk($sformatf("rnd%0d_op%0h_cycles", n, op), r_cycles, e.cycles);
      chk($sformatf("rnd%0d_op%0h_pcw", n, op), r_pcw, e.pcw);
      chk($sformatf("rnd%0d_op%0h_rw", n, op), r_rw, e.rw);
      chk($sformatf("rnd%0d_op%0h_mr", n, op), r_mr, e.mr);
      chk($sformatf("rnd%0d_op%0h_mw", n, op), r_mw, e.mw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
